// File: rtl/slip_pkg.sv
// Shared SLIP codes and encoder state encoding; the read-side decoder imports this too.
package slip_pkg;
  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_TERM} slip_enc_state_t;
endpackage

// File: rtl/slip_fifo_wr_encoder.sv
// SLIP byte-stuffing framer feeding an async FIFO write port through a single output slot.
module slip_fifo_wr_encoder
  import slip_pkg::*;
#(
  parameter int               DSIZE      = 8,
  parameter logic [DSIZE-1:0] END_CODE   = DSIZE'(SLIP_END),
  parameter logic [DSIZE-1:0] ESC_CODE   = DSIZE'(SLIP_ESC),
  parameter logic [DSIZE-1:0] ESC_END    = DSIZE'(SLIP_ESC_END),
  parameter logic [DSIZE-1:0] ESC_ESC    = DSIZE'(SLIP_ESC_ESC),
  parameter bit               EMIT_START = 1'b1,
  parameter int               CNT_W      = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [DSIZE-1:0] wdata,
  output logic             winc,
  input  logic             wfull,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  slip_enc_state_t  state;
  logic [DSIZE-1:0] out_byte;
  logic [DSIZE-1:0] second;
  logic             out_vld;
  logic             last_q;
  logic             slot_free;
  logic             accept;

  always_comb begin
    winc      = out_vld & ~wfull;
    slot_free = ~out_vld | winc;
    in_ready  = (state == S_DATA) & slot_free;
    accept    = in_valid & in_ready;
    wdata     = out_byte;
    busy      = (state != S_IDLE) | out_vld;
  end

  // A load in the same cycle as a drain overrides the clear of out_vld.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= S_IDLE;
      out_byte  <= '0;
      out_vld   <= 1'b0;
      second    <= '0;
      last_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (winc) out_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (EMIT_START) begin
              if (slot_free) begin
                out_byte <= END_CODE;
                out_vld  <= 1'b1;
                state    <= S_DATA;
              end
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            last_q  <= in_last;
            out_vld <= 1'b1;
            if (in_data == END_CODE) begin
              out_byte <= ESC_CODE;
              second   <= ESC_END;
              state    <= S_ESC;
            end else if (in_data == ESC_CODE) begin
              out_byte <= ESC_CODE;
              second   <= ESC_ESC;
              state    <= S_ESC;
            end else begin
              out_byte <= in_data;
              state    <= in_last ? S_TERM : S_DATA;
            end
          end
        end
        S_ESC: begin
          if (slot_free) begin
            out_byte <= second;
            out_vld  <= 1'b1;
            state    <= last_q ? S_TERM : S_DATA;
          end
        end
        S_TERM: begin
          if (slot_free) begin
            out_byte  <= END_CODE;
            out_vld   <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slip_fifo_wr_encoder.sv
// Bench: instance 0 with leading END, instance 1 trailing-only; scoreboard of expected FIFO writes.
module tb_slip_fifo_wr_encoder;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        wfull = 1'b0;
  logic [7:0]  in_data  [2];
  logic        in_valid [2];
  logic        in_last  [2];
  logic        in_ready [2];
  logic [7:0]  wdata    [2];
  logic        winc     [2];
  logic [15:0] frame_cnt[2];
  logic        busy     [2];

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [8:0] tx_q[$];
  int exp_fc[2];

  always #5 wclk = ~wclk;

  slip_fifo_wr_encoder #(.EMIT_START(1'b1)) u_a (
    .wclk(wclk), .wrst_n(wrst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .wdata(wdata[0]), .winc(winc[0]),
    .wfull(wfull), .frame_cnt(frame_cnt[0]), .busy(busy[0]));

  slip_fifo_wr_encoder #(.EMIT_START(1'b0)) u_b (
    .wclk(wclk), .wrst_n(wrst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .wdata(wdata[1]), .winc(winc[1]),
    .wfull(wfull), .frame_cnt(frame_cnt[1]), .busy(busy[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard, stall and escape monitors, sampled on the falling edge.
  logic       wfull_d = 1'b0;
  logic [7:0] wdata_d [2];
  logic       esc_next[2] = '{1'b0, 1'b0};
  always @(negedge wclk) begin
    for (int i = 0; i < 2; i++) begin
      if (winc[i] === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_write", {24'h0, wdata[i]}, 32'hFFFF_FFFF);
        else check("wdata", {24'h0, wdata[i]}, {24'h0, exp_q.pop_front()});
      end
      if (wfull && wrst_n) begin
        check("winc_while_full", {31'h0, winc[i]}, 32'h0);
        if (wfull_d) check("wdata_stable_in_stall", {24'h0, wdata[i]}, {24'h0, wdata_d[i]});
      end
      if (esc_next[i]) check("in_ready_in_esc", {31'h0, in_ready[i]}, 32'h0);
      esc_next[i] = in_valid[i] && in_ready[i] && (in_data[i] == 8'hC0 || in_data[i] == 8'hDB);
      wdata_d[i] = wdata[i];
    end
    wfull_d = wfull;
  end

  task automatic run_stream(input int inst);
    while (tx_q.size() > 0) begin
      logic [8:0] it;
      logic acc;
      int cyc;
      it = tx_q.pop_front();
      in_data[inst] = it[7:0];
      in_last[inst] = it[8];
      in_valid[inst] = 1'b1;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 300) begin
        @(negedge wclk);
        acc = in_ready[inst];
        @(posedge wclk); #1;
        cyc++;
      end
      check("accept_timeout", {31'h0, acc}, 32'h1);
    end
    in_valid[inst] = 1'b0;
    in_last[inst] = 1'b0;
  endtask

  task automatic drain(input int inst);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy[inst]) && cyc < 300) begin
      @(posedge wclk); #1;
      cyc++;
    end
    check("drain_timeout", {31'h0, cyc < 300}, 32'h1);
    check("frame_cnt", {16'h0, frame_cnt[inst]}, exp_fc[inst]);
  endtask

  typedef struct {
    int         inst;
    int         n;
    logic [7:0] d[4];
    int         m;
    logic [7:0] e[8];
    bit         stall;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 3, '{8'h01, 8'h02, 8'h03, 8'h00}, 5,
                '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[1] = '{0, 3, '{8'hC0, 8'hDB, 8'h7F, 8'h00}, 7,
                '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h7F, 8'hC0, 8'h00}, 1'b0};
    vecs[2] = '{0, 4, '{8'h10, 8'h20, 8'h30, 8'h40}, 6,
                '{8'hC0, 8'h10, 8'h20, 8'h30, 8'h40, 8'hC0, 8'h00, 8'h00}, 1'b1};
    vecs[3] = '{0, 1, '{8'hC0, 8'h00, 8'h00, 8'h00}, 4,
                '{8'hC0, 8'hDB, 8'hDC, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[4] = '{1, 1, '{8'hDB, 8'h00, 8'h00, 8'h00}, 3,
                '{8'hDB, 8'hDD, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    exp_fc = '{0, 0};
    for (int i = 0; i < 2; i++) begin
      in_data[i] = 8'h00; in_valid[i] = 1'b0; in_last[i] = 1'b0;
    end

    // Reset state, with in_valid asserted to show it is ignored.
    in_valid[0] = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    check("rst_winc", {31'h0, winc[0]}, 32'h0);
    check("rst_wdata", {24'h0, wdata[0]}, 32'h0);
    check("rst_frame_cnt", {16'h0, frame_cnt[0]}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready[0]}, 32'h0);
    check("rst_busy", {31'h0, busy[0]}, 32'h0);
    in_valid[0] = 1'b0;
    wrst_n = 1'b1;
    @(posedge wclk); #1;

    foreach (vecs[v]) begin
      for (int j = 0; j < vecs[v].m; j++) exp_q.push_back(vecs[v].e[j]);
      for (int j = 0; j < vecs[v].n; j++) tx_q.push_back({j == vecs[v].n - 1, vecs[v].d[j]});
      exp_fc[vecs[v].inst]++;
      if (vecs[v].stall) begin
        fork
          run_stream(vecs[v].inst);
          begin
            repeat (2) @(posedge wclk);
            #1 wfull = 1'b1;
            repeat (5) @(posedge wclk);
            #1 wfull = 1'b0;
          end
        join
      end else begin
        run_stream(vecs[v].inst);
      end
      drain(vecs[v].inst);
    end

    // Back-to-back single-byte packets with in_valid held high.
    exp_q = '{8'hC0, 8'hAA, 8'hC0, 8'hC0, 8'hBB, 8'hC0};
    tx_q = '{9'h1AA, 9'h1BB};
    exp_fc[0] += 2;
    run_stream(0);
    drain(0);

    // Reset mid-frame, after 02 is accepted and before 03 is offered.
    exp_q = '{8'hC0, 8'h01};
    tx_q = '{9'h001, 9'h002};
    run_stream(0);
    wrst_n = 1'b0;
    #1;
    check("midrst_winc", {31'h0, winc[0]}, 32'h0);
    check("midrst_frame_cnt", {16'h0, frame_cnt[0]}, 32'h0);
    check("midrst_busy", {31'h0, busy[0]}, 32'h0);
    check("midrst_pending_writes", exp_q.size(), 32'h0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    exp_fc[0] = 1;
    exp_q = '{8'hC0, 8'h03, 8'hC0};
    tx_q = '{9'h103};
    run_stream(0);
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
